// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch sequencer.
//   RomAddr / ROM_ADDR_W : instruction ROM address type and width; the fetch
//                          controller's ADDR_W defaults to this width.
//   TRAP_VEC             : PC target used when a trap redirect wins
//                          (only referenced when FETCH_TRAP_EN is defined).
//   fetch_state_e        : sequencer states.
//   redir_prio_e         : 2-bit redirect priority, higher value wins.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int ROM_ADDR_W = 6;
  typedef logic [ROM_ADDR_W-1:0] RomAddr;

  localparam RomAddr TRAP_VEC = 6'h3C;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_STALL = 3'd2,
    ST_DRAIN = 3'd3,
    ST_REDIR = 3'd4,
    ST_HALT  = 3'd5
  } fetch_state_e;

  // Numeric order matters: a pending redirect is replaced by one of >= value.
  typedef enum logic [1:0] {
    PRIO_NONE = 2'd0,
    PRIO_JMP  = 2'd1,
    PRIO_BR   = 2'd2,
    PRIO_TRAP = 2'd3
  } redir_prio_e;

endpackage

// File: rtl/fetch_redirect_arb.sv
// -----------------------------------------------------------------------------
// fetch_redirect_arb
// Combinational fixed-priority pick among redirect sources:
// trap > branch > jump (trap only present when FETCH_TRAP_EN is defined).
//   i_trap                    : trap request, target is TRAP_VEC
//   i_br_valid / i_br_target  : branch redirect from EX
//   i_jmp_valid / i_jmp_target: jump redirect from ID
//   o_valid / o_target / o_prio : winning redirect (target 0, PRIO_NONE if none)
// Configuration macro: FETCH_TRAP_EN
// -----------------------------------------------------------------------------
module fetch_redirect_arb
  import fetch_pkg::*;
#(
  parameter int ADDR_W = ROM_ADDR_W
) (
`ifdef FETCH_TRAP_EN
  input  logic              i_trap,
`endif
  input  logic              i_br_valid,
  input  logic [ADDR_W-1:0] i_br_target,
  input  logic              i_jmp_valid,
  input  logic [ADDR_W-1:0] i_jmp_target,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_target,
  output redir_prio_e       o_prio
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    o_valid  = 1'b0;
    o_target = '0;
    o_prio   = PRIO_NONE;
`ifdef FETCH_TRAP_EN
    if (i_trap) begin
      o_valid  = 1'b1;
      o_target = ADDR_W'(TRAP_VEC);
      o_prio   = PRIO_TRAP;
    end else
`endif
    if (i_br_valid) begin
      o_valid  = 1'b1;
      o_target = i_br_target;
      o_prio   = PRIO_BR;
    end else if (i_jmp_valid) begin
      o_valid  = 1'b1;
      o_target = i_jmp_target;
      o_prio   = PRIO_JMP;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer between PC, instruction ROM and decode.
// Runs the ROM req/ack handshake, arbitrates redirects, applies hazard stalls,
// flushes wrong-path instructions and halts on a ROM acknowledge timeout.
//   clk, resetIn (async, active-low)
//   stallIn                 : hazard stall
//   brValid/brTarget        : branch redirect
//   jmpValid/jmpTarget      : jump redirect
//   trapReq                 : trap redirect (FETCH_TRAP_EN only)
//   romAck / romReq         : ROM handshake
//   pcResetOut, pcEnable, pcSelect, pcJump : PC controls
//   instValid, flushOut     : decode-side qualifiers
//   fetchErr                : sticky ROM timeout flag
// Configuration macro: FETCH_TRAP_EN
// All outputs are combinational from state and inputs.
// -----------------------------------------------------------------------------
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W      = ROM_ADDR_W,
  parameter int ROM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic              stallIn,
  input  logic              brValid,
  input  logic [ADDR_W-1:0] brTarget,
  input  logic              jmpValid,
  input  logic [ADDR_W-1:0] jmpTarget,
`ifdef FETCH_TRAP_EN
  input  logic              trapReq,
`endif
  input  logic              romAck,
  output logic              romReq,
  output logic              pcResetOut,
  output logic              pcEnable,
  output logic              pcSelect,
  output logic [ADDR_W-1:0] pcJump,
  output logic              instValid,
  output logic              flushOut,
  output logic              fetchErr
);

  fetch_state_e      r_state;
  fetch_state_e      w_next_state;
  logic [ADDR_W-1:0] r_pend_target;
  redir_prio_e       r_pend_prio;
  logic [7:0]        r_wait;
  logic              r_fetch_err;

  logic              w_rd_valid;
  logic [ADDR_W-1:0] w_rd_target;
  redir_prio_e       w_rd_prio;
  logic              w_req_state;
  logic              w_timeout;
  logic              w_pend_load;

  fetch_redirect_arb #(.ADDR_W(ADDR_W)) u_arb (
`ifdef FETCH_TRAP_EN
    .i_trap       (trapReq),
`endif
    .i_br_valid   (brValid),
    .i_br_target  (brTarget),
    .i_jmp_valid  (jmpValid),
    .i_jmp_target (jmpTarget),
    .o_valid      (w_rd_valid),
    .o_target     (w_rd_target),
    .o_prio       (w_rd_prio)
  );

  // romReq is high exactly in these states, so it never drops before romAck
  // except on timeout (state leaves to HALT) or reset.
  assign w_req_state = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  // Fires on the ROM_TIMEOUT-th consecutive unacknowledged request cycle.
  assign w_timeout   = w_req_state && !romAck && (r_wait == 8'(ROM_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) r_state <= ST_BOOT;
    else          r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    w_pend_load  = 1'b0;
    unique case (r_state)
      ST_BOOT:  w_next_state = ST_FETCH;
      ST_FETCH: begin
        if (w_timeout) begin
          w_next_state = ST_HALT;
        end else if (romAck) begin
          // Stall only matters once an instruction has actually arrived.
          if (!w_rd_valid && stallIn) w_next_state = ST_STALL;
        end else if (w_rd_valid) begin
          // Request still in flight: park the redirect until the ROM answers.
          w_pend_load  = 1'b1;
          w_next_state = ST_DRAIN;
        end
      end
      ST_STALL: begin
        if (w_rd_valid || !stallIn) w_next_state = ST_FETCH;
      end
      ST_DRAIN: begin
        w_pend_load = w_rd_valid && (w_rd_prio >= r_pend_prio);
        if (w_timeout)   w_next_state = ST_HALT;
        else if (romAck) w_next_state = ST_REDIR;
      end
      ST_REDIR: w_next_state = ST_FETCH;
      ST_HALT:  w_next_state = ST_HALT;
      default:  w_next_state = ST_BOOT;
    endcase
  end

  // Pending redirect, wait counter and sticky error
  always_ff @(posedge clk or negedge resetIn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    if (!resetIn) begin
      r_pend_target <= '0;
      r_pend_prio   <= PRIO_NONE;
      r_wait        <= '0;
      r_fetch_err   <= 1'b0;
    end else begin
      if (w_pend_load) begin
        r_pend_target <= w_rd_target;
        r_pend_prio   <= w_rd_prio;
      end else if (r_state == ST_REDIR) begin
        r_pend_target <= '0;
        r_pend_prio   <= PRIO_NONE;
      end
      // Clearing whenever romReq is low also clears it at each rising edge.
      if (!w_req_state || romAck) r_wait <= '0;
      else                        r_wait <= r_wait + 8'd1;
      if (w_timeout) r_fetch_err <= 1'b1;
    end
  end

  assign fetchErr = r_fetch_err;

  // Output logic
  always_comb begin
    romReq     = 1'b0;
    pcResetOut = 1'b0;
    pcEnable   = 1'b0;
    pcSelect   = 1'b0;
    pcJump     = '0;
    instValid  = 1'b0;
    flushOut   = 1'b0;
    unique case (r_state)
      ST_BOOT: pcResetOut = 1'b1;
      ST_FETCH: begin
        romReq = 1'b1;
        pcJump = w_rd_target;
        if (romAck) begin
          if (w_rd_valid) begin
            pcEnable = 1'b1;
            pcSelect = 1'b1;
            flushOut = 1'b1;
          end else if (!stallIn) begin
            pcEnable  = 1'b1;
            instValid = 1'b1;
          end
        end
      end
      ST_STALL: begin
        pcJump = w_rd_target;
        if (w_rd_valid) begin
          pcEnable = 1'b1;
          pcSelect = 1'b1;
          flushOut = 1'b1;
        end
      end
      ST_DRAIN: begin
        romReq = 1'b1;
        pcJump = w_rd_target;
      end
      ST_REDIR: begin
        pcEnable = 1'b1;
        pcSelect = 1'b1;
        pcJump   = r_pend_target;
        flushOut = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// against a behavioural reference model. Define FETCH_TRAP_EN to include the
// trap port and trap scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int AW      = 6;
  localparam int TIMEOUT = 15;

  // Control vector bit positions
  localparam int B_REQ = 6, B_PCRST = 5, B_EN = 4, B_SEL = 3, B_INST = 2, B_FLUSH = 1, B_ERR = 0;
  localparam logic [6:0] C_BOOT     = 7'b0100000;
  localparam logic [6:0] C_RUN      = 7'b1010100;
  localparam logic [6:0] C_WAIT     = 7'b1000000;
  localparam logic [6:0] C_ACK_RDR  = 7'b1011010;
  localparam logic [6:0] C_REDIR    = 7'b0011010;
  localparam logic [6:0] C_IDLE     = 7'b0000000;
  localparam logic [6:0] C_HALT     = 7'b0000001;

  logic          clk = 1'b0;
  logic          resetIn, stallIn, brValid, jmpValid, romAck;
  logic [AW-1:0] brTarget, jmpTarget;
  logic          trapReq;
  logic          romReq, pcResetOut, pcEnable, pcSelect, instValid, flushOut, fetchErr;
  logic [AW-1:0] pcJump;
  logic [6:0]    w_ctl;
  logic [AW-1:0] pc;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_ctrl #(.ADDR_W(AW), .ROM_TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .resetIn    (resetIn),
    .stallIn    (stallIn),
    .brValid    (brValid),
    .brTarget   (brTarget),
    .jmpValid   (jmpValid),
    .jmpTarget  (jmpTarget),
`ifdef FETCH_TRAP_EN
    .trapReq    (trapReq),
`endif
    .romAck     (romAck),
    .romReq     (romReq),
    .pcResetOut (pcResetOut),
    .pcEnable   (pcEnable),
    .pcSelect   (pcSelect),
    .pcJump     (pcJump),
    .instValid  (instValid),
    .flushOut   (flushOut),
    .fetchErr   (fetchErr)
  );

  always #5 clk = ~clk;

  assign w_ctl = {romReq, pcResetOut, pcEnable, pcSelect, instValid, flushOut, fetchErr};

  // Program counter as the PC block would behave under these controls.
  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn)        pc <= '0;
    else if (pcResetOut) pc <= '0;
    else if (pcEnable)   pc <= pcSelect ? pcJump : pc + 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input bit ok, input string msg);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s", msg);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stallIn = 0; brValid = 0; jmpValid = 0; romAck = 0; trapReq = 0;
    brTarget = '0; jmpTarget = '0;
  endtask

  // Leaves the bench at the start of the BOOT cycle.
  task automatic do_reset();
    resetIn = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 resetIn = 1'b1;
  endtask

  task automatic test_reset();
    resetIn = 1'b0;
    clear_inputs();
    @(negedge clk);
    check({w_ctl, pcJump} === {C_BOOT, 6'h00},
          $sformatf("reset_state: got ctl=%b jump=%h, expected ctl=%b jump=00", w_ctl, pcJump, C_BOOT));
    step();
    resetIn = 1'b1;
    @(negedge clk);
    check(w_ctl === C_BOOT,
          $sformatf("boot_cycle: got ctl=%b, expected %b", w_ctl, C_BOOT));
    step();
    @(negedge clk);
    check(w_ctl === C_WAIT,
          $sformatf("first_req: got ctl=%b, expected %b", w_ctl, C_WAIT));
    // Reset in the middle of an outstanding request drops romReq at once.
    step();
    resetIn = 1'b0;
    #1;
    check(w_ctl === C_BOOT,
          $sformatf("reset_mid_req: got ctl=%b, expected %b", w_ctl, C_BOOT));
    resetIn = 1'b1;
  endtask

  task automatic test_zero_wait();
    do_reset();
    romAck = 1'b1;
    @(negedge clk);
    check(w_ctl === C_BOOT,
          $sformatf("zw_boot: got ctl=%b, expected %b", w_ctl, C_BOOT));
    step();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check(w_ctl === C_RUN && pc === AW'(i),
            $sformatf("zw_run[%0d]: got ctl=%b pc=%h, expected ctl=%b pc=%h", i, w_ctl, pc, C_RUN, AW'(i)));
      step();
    end
  endtask

  task automatic test_drain_redirect();
    do_reset();
    step();
    brValid = 1'b1; brTarget = 6'h20;
    @(negedge clk);
    check({w_ctl, pcJump} === {C_WAIT, 6'h20},
          $sformatf("dr_latch: got ctl=%b jump=%h, expected ctl=%b jump=20", w_ctl, pcJump, C_WAIT));
    step();
    brValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      romAck = (i == 2);
      @(negedge clk);
      check(w_ctl === C_WAIT,
            $sformatf("dr_drain[%0d]: got ctl=%b, expected %b", i, w_ctl, C_WAIT));
      step();
    end
    romAck = 1'b0;
    @(negedge clk);
    check({w_ctl, pcJump} === {C_REDIR, 6'h20},
          $sformatf("dr_redir: got ctl=%b jump=%h, expected ctl=%b jump=20", w_ctl, pcJump, C_REDIR));
    step();
    romAck = 1'b1;
    @(negedge clk);
    check(w_ctl === C_RUN && pc === 6'h20,
          $sformatf("dr_resume: got ctl=%b pc=%h, expected ctl=%b pc=20", w_ctl, pc, C_RUN));
    step();
  endtask

  // first/second redirect arrive in FETCH and DRAIN; REDIR must show exp.
  task automatic drain_pair(input bit first_br, input logic [AW-1:0] first_t,
                            input bit second_br, input logic [AW-1:0] second_t,
                            input logic [AW-1:0] exp, input string name);
    romAck = 1'b0;
    brValid = first_br; jmpValid = !first_br;
    brTarget = first_t; jmpTarget = first_t;
    step();
    brValid = second_br; jmpValid = !second_br;
    brTarget = second_t; jmpTarget = second_t;
    step();
    brValid = 1'b0; jmpValid = 1'b0; romAck = 1'b1;
    step();
    romAck = 1'b0;
    @(negedge clk);
    check({w_ctl, pcJump} === {C_REDIR, exp},
          $sformatf("%s: got ctl=%b jump=%h, expected ctl=%b jump=%h", name, w_ctl, pcJump, C_REDIR, exp));
    step();
  endtask

  task automatic test_drain_priority();
    do_reset();
    step();
    drain_pair(1'b0, 6'h10, 1'b1, 6'h30, 6'h30, "prio_jmp_then_br");
    drain_pair(1'b1, 6'h30, 1'b0, 6'h10, 6'h30, "prio_br_then_jmp");
    drain_pair(1'b1, 6'h30, 1'b1, 6'h0A, 6'h0A, "prio_br_then_br");
  endtask

  task automatic test_stall();
    logic [AW-1:0] saved;
    do_reset();
    romAck = 1'b1;
    step();
    @(negedge clk);
    check(w_ctl === C_RUN,
          $sformatf("st_run: got ctl=%b, expected %b", w_ctl, C_RUN));
    step();
    stallIn = 1'b1;
    @(negedge clk);
    saved = pc;
    check(w_ctl === C_WAIT,
          $sformatf("st_ack_stall: got ctl=%b, expected %b", w_ctl, C_WAIT));
    step();
    for (int i = 0; i < 3; i++) begin
      stallIn = (i < 2);
      @(negedge clk);
      check(w_ctl === C_IDLE,
            $sformatf("st_hold[%0d]: got ctl=%b, expected %b", i, w_ctl, C_IDLE));
      step();
    end
    @(negedge clk);
    check(w_ctl === C_RUN && pc === saved,
          $sformatf("st_refetch: got ctl=%b pc=%h, expected ctl=%b pc=%h", w_ctl, pc, C_RUN, saved));
    step();
    stallIn = 1'b1;
    step();
    jmpValid = 1'b1; jmpTarget = 6'h15;
    @(negedge clk);
    check({w_ctl, pcJump} === {C_REDIR, 6'h15},
          $sformatf("st_redirect: got ctl=%b jump=%h, expected ctl=%b jump=15", w_ctl, pcJump, C_REDIR));
    step();
    jmpValid = 1'b0; stallIn = 1'b0;
    @(negedge clk);
    check(w_ctl === C_RUN && pc === 6'h15,
          $sformatf("st_after_redirect: got ctl=%b pc=%h, expected ctl=%b pc=15", w_ctl, pc, C_RUN));
    step();
  endtask

  task automatic test_timeout();
    do_reset();
    step();
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk);
      check(w_ctl === C_WAIT,
            $sformatf("to_wait[%0d]: got ctl=%b, expected %b", i, w_ctl, C_WAIT));
      step();
    end
    romAck = 1'b1; brValid = 1'b1; brTarget = 6'h2A;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({w_ctl, pcJump} === {C_HALT, 6'h00},
            $sformatf("to_halt[%0d]: got ctl=%b jump=%h, expected ctl=%b jump=00", i, w_ctl, pcJump, C_HALT));
      step();
    end
    resetIn = 1'b0;
    #1;
    check(w_ctl === C_BOOT,
          $sformatf("to_reset_clears: got ctl=%b, expected %b", w_ctl, C_BOOT));
    resetIn = 1'b1;
    clear_inputs();
  endtask

`ifdef FETCH_TRAP_EN
  task automatic test_trap();
    do_reset();
    step();
    trapReq = 1'b1; brValid = 1'b1; brTarget = 6'h22; romAck = 1'b1;
    @(negedge clk);
    check({w_ctl, pcJump} === {C_ACK_RDR, TRAP_VEC},
          $sformatf("trap_prio: got ctl=%b jump=%h, expected ctl=%b jump=%h", w_ctl, pcJump, C_ACK_RDR, TRAP_VEC));
    step();
    clear_inputs();
  endtask
`endif

  // Randomized run against a reference model built from the sequencing rules:
  // one request at a time, redirects either applied with the ack or parked
  // (highest rank, later wins ties) until the ROM answers, stalls only after
  // an acknowledged instruction, timeout after TIMEOUT unanswered cycles.
  task automatic test_random();
    bit            booting, halted, holding, draining, apply, err, do_rst;
    int            pend_rank, rank, waits;
    logic [AW-1:0] pend_tgt, tgt, exp_jump;
    logic [6:0]    exp_ctl;
    do_reset();
    booting = 1; halted = 0; holding = 0; draining = 0; apply = 0; err = 0;
    pend_rank = 0; pend_tgt = '0; waits = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      do_rst    = ($urandom_range(0, 149) == 0);
      resetIn   = !do_rst;
      stallIn   = ($urandom_range(0, 9) < 3);
      brValid   = ($urandom_range(0, 9) < 2);
      jmpValid  = ($urandom_range(0, 9) < 2);
      brTarget  = AW'($urandom);
      jmpTarget = AW'($urandom);
      romAck    = ($urandom_range(0, 9) < 6);
`ifdef FETCH_TRAP_EN
      trapReq   = ($urandom_range(0, 19) == 0);
`endif
      rank = 0; tgt = '0;
`ifdef FETCH_TRAP_EN
      if (trapReq) begin rank = 3; tgt = TRAP_VEC; end else
`endif
      if (brValid)       begin rank = 2; tgt = brTarget;  end
      else if (jmpValid) begin rank = 1; tgt = jmpTarget; end

      exp_ctl = '0; exp_jump = '0;
      if (do_rst) begin
        booting = 1; halted = 0; holding = 0; draining = 0; apply = 0; err = 0;
        pend_rank = 0; pend_tgt = '0; waits = 0;
        exp_ctl = C_BOOT;
      end else begin
        exp_ctl[B_ERR] = err;
        if (halted) begin
        end else if (booting) begin
          exp_ctl[B_PCRST] = 1'b1;
        end else if (apply) begin
          exp_ctl[B_EN] = 1'b1; exp_ctl[B_SEL] = 1'b1; exp_ctl[B_FLUSH] = 1'b1;
          exp_jump = pend_tgt;
        end else if (holding) begin
          exp_jump = tgt;
          if (rank != 0) begin
            exp_ctl[B_EN] = 1'b1; exp_ctl[B_SEL] = 1'b1; exp_ctl[B_FLUSH] = 1'b1;
          end
        end else begin
          exp_ctl[B_REQ] = 1'b1;
          exp_jump = tgt;
          if (!draining && romAck) begin
            if (rank != 0) begin
              exp_ctl[B_EN] = 1'b1; exp_ctl[B_SEL] = 1'b1; exp_ctl[B_FLUSH] = 1'b1;
            end else if (!stallIn) begin
              exp_ctl[B_EN] = 1'b1; exp_ctl[B_INST] = 1'b1;
            end
          end
        end
      end

      @(negedge clk);
      check({w_ctl, pcJump} === {exp_ctl, exp_jump},
            $sformatf("rand[%0d]: got ctl=%b jump=%h, expected ctl=%b jump=%h",
                      cyc, w_ctl, pcJump, exp_ctl, exp_jump));

      if (!do_rst) begin
        if (halted) begin
        end else if (booting) begin
          booting = 0; waits = 0;
        end else if (apply) begin
          apply = 0; pend_rank = 0; pend_tgt = '0; waits = 0;
        end else if (holding) begin
          waits = 0;
          if (rank != 0 || !stallIn) holding = 0;
        end else if (romAck) begin
          waits = 0;
          if (draining) begin
            if (rank != 0 && rank >= pend_rank) begin pend_rank = rank; pend_tgt = tgt; end
            draining = 0; apply = 1;
          end else if (rank == 0 && stallIn) begin
            holding = 1;
          end
        end else begin
          waits++;
          if (waits >= TIMEOUT) begin
            halted = 1; err = 1; draining = 0;
          end else if (rank != 0 && (!draining || rank >= pend_rank)) begin
            draining = 1; pend_rank = rank; pend_tgt = tgt;
          end
        end
      end
      step();
    end
    resetIn = 1'b1;
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    resetIn = 1'b0;
    test_reset();
    test_zero_wait();
    test_drain_redirect();
    test_drain_priority();
    test_stall();
    test_timeout();
`ifdef FETCH_TRAP_EN
    test_trap();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed -- %s", n_tests, n_fail, (n_fail == 0) ? "PASS" : "FAIL");
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer sitting between the program counter, the instruction ROM and the decode stage. It drives the PC's enable/select/jump-target/reset controls and runs a request/acknowledge handshake with the ROM. It arbitrates redirect sources (trap, branch, jump) and applies hazard stalls. It flushes wrong-path instructions and detects ROM timeouts.

## Interface
- ADDR_W, 6, instruction address width; must equal the shared `RomAddr` width
- ROM_TIMEOUT, 15, maximum cycles a ROM request may wait for acknowledge (1..255)

- clk  in  1  clock, rising edge
- resetIn  in  1  reset, asynchronous, active-low
- stallIn  in  1  hazard stall from decode/hazard unit
- brValid  in  1  branch redirect request from EX
- brTarget  in  ADDR_W  branch target
- jmpValid  in  1  jump redirect request from ID
- jmpTarget  in  ADDR_W  jump target
- trapReq  in  1  trap request (only with FETCH_TRAP_EN)
- romAck  in  1  ROM has presented the instruction for the current request
- romReq  out  1  fetch request to ROM
- pcResetOut  out  1  synchronous reset to PC (active-high)
- pcEnable  out  1  PC update enable
- pcSelect  out  1  PC source: 1 = pcJump, 0 = increment
- pcJump  out  ADDR_W  redirect target to PC
- instValid  out  1  instruction on ROM data bus is valid for decode this cycle
- flushOut  out  1  invalidate IF/ID register
- fetchErr  out  1  sticky ROM timeout flag

## Operation
- States: BOOT, FETCH, STALL, DRAIN, REDIR, HALT.
- Redirect priority: trap > branch > jump. pcJump = winning target, or the pending target in REDIR.
- BOOT: pcResetOut=1, romReq=0. Next cycle goes to FETCH.
- FETCH: romReq=1. Once raised, romReq stays high until romAck.
  - romAck & redirect: pcEnable=1, pcSelect=1, flushOut=1, instValid=0. Stay in FETCH.
  - romAck & stallIn & no redirect: pcEnable=0, instValid=0. Go to STALL; the same address is refetched later.
  - romAck & no stall & no redirect: pcEnable=1, pcSelect=0, instValid=1.
  - No romAck & redirect: latch target and priority into the pending register. Go to DRAIN.
  - No romAck & no redirect: stallIn is ignored.
- STALL: romReq=0.
  - Redirect: applied immediately as above (flushOut=1). Go to FETCH.
  - Otherwise, !stallIn: go to FETCH.
- DRAIN: romReq=1, instValid=0.
  - A new redirect overwrites the pending register only if its priority is >= the pending priority.
  - romAck: discard the response. Go to REDIR.
- REDIR: romReq=0, pcEnable=1, pcSelect=1, pcJump=pending target, flushOut=1. Go to FETCH. Redirect inputs are ignored this cycle.
- Timeout: the wait counter clears on every romReq rising edge and on romAck.
  - It increments each cycle that romReq=1 & !romAck.
  - When the counter reaches ROM_TIMEOUT: set fetchErr, drop romReq, go to HALT.
- HALT: all outputs 0 except fetchErr=1. Only reset exits HALT.

## Timing
- During reset: state=BOOT, pending cleared, counter=0, pcResetOut=1, all other outputs 0 (fetchErr=0).
- First romReq appears 1 cycle after resetIn deasserts, following the BOOT cycle.
- Zero-wait ROM (romAck in the same cycle as romReq) sustains one instruction per cycle.
- Redirect latency:
  - 0 cycles (PC loads on the next edge) when romAck is present or the state is STALL.
  - Otherwise the acknowledge wait plus 1 cycle (DRAIN then REDIR).
- Outputs are combinational from state and inputs. State, pending register, counter and fetchErr are registered.
- resetIn assertion mid-request immediately drops romReq and returns to BOOT. The ROM must tolerate an abandoned request.

## Configuration
- FETCH_TRAP_EN defined: trapReq is present and has highest priority; its target is the package constant TRAP_VEC.
- FETCH_TRAP_EN undefined: the trapReq port and trap logic are removed; priority is branch > jump.

## Structure
- Shared package fetch_pkg holds:
  - the state enumeration;
  - the 2-bit redirect priority encoding (NONE, JMP, BR, TRAP);
  - TRAP_VEC;
  - ADDR_W tied to the shared ROM address definitions.
- One sub-module, fetch_redirect_arb: combinational priority pick returning valid, target and priority.

## Test plan
- Reset then zero-wait ROM, no stall: pcResetOut=1 for exactly the BOOT cycle, then pcEnable=1, pcSelect=0, instValid=1 every cycle.
- romAck delayed 3 cycles with brValid=1, brTarget=0x20 in the first wait cycle:
  - DRAIN for 3 cycles, then REDIR with pcJump=0x20 and flushOut=1;
  - no instValid during the sequence.
- In DRAIN with a pending jump (0x10), brValid with 0x30 arrives: REDIR uses 0x30. The reverse order keeps 0x30.
- romAck with stallIn=1 for 2 cycles:
  - pcEnable=0 and romReq=0 throughout;
  - FETCH resumes and the same address is refetched;
  - a jmpValid during the stall redirects immediately with flushOut=1.
- romAck withheld for ROM_TIMEOUT cycles: fetchErr=1 and romReq=0, held until resetIn pulses low.
- With FETCH_TRAP_EN, trapReq and brValid in the same cycle: pcJump=TRAP_VEC.
